// File: rtl/scc_mapper_pkg.sv
// scc_mapper_pkg: shared widths, types and reset values for the SCC ROM mapper
package scc_mapper_pkg;
  localparam int BANK_W = 6;
  localparam int NUM_PAGES = 4;
  typedef logic [1:0] page_t;
  typedef logic [BANK_W-1:0] bank_t;
  function automatic bank_t reset_bank(input page_t p);
    return bank_t'(p);
  endfunction
endpackage

// File: rtl/scc_bank_regfile.sv
// scc_bank_regfile: 4x6 bank registers, reset to page index, one write and one async read port
module scc_bank_regfile
  import scc_mapper_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  page_t wpage,
  input  bank_t wdata,
  input  page_t rpage,
  output bank_t rdata
);
  bank_t bank [NUM_PAGES];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PAGES; i++) bank[i] <= reset_bank(page_t'(i));
    end else if (we) begin
      bank[wpage] <= wdata;
    end
  end
  assign rdata = bank[rpage];
endmodule

// File: rtl/scc_rom_mapper_sync.sv
// scc_rom_mapper_sync: Konami-SCC-style bank mapper driving ROM A18..A13 for the 4000h-BFFFh window
module scc_rom_mapper_sync
  import scc_mapper_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              sltsl_n,
  input  logic [7:0]        a7_a0,
  input  logic [2:0]        a15_a13_a12,
  input  logic [BANK_W-1:0] data,
  output logic [BANK_W-1:0] address_upper
);
  page_t page;
  logic  we;
  // Read qualification and low address bits are handled outside this block.
  logic  unused_ok;
  assign unused_ok = ^{rd_n, a7_a0};
  assign page = a15_a13_a12[2:1];
  assign we = !sltsl_n && !wr_n && a15_a13_a12[0];
  scc_bank_regfile u_regs (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wpage (page),
    .wdata (data),
    .rpage (page),
    .rdata (address_upper)
  );
endmodule

// File: tb/tb_scc_rom_mapper_sync.sv
// tb_scc_rom_mapper_sync: vector table, held-write sequence and randomized run against a bank model
module tb_scc_rom_mapper_sync;
  logic       clk = 0;
  logic       reset = 1;
  logic       rd_n = 1;
  logic       wr_n = 1;
  logic       sltsl_n = 1;
  logic [7:0] a7_a0 = 0;
  logic [2:0] a15_a13_a12 = 0;
  logic [5:0] data = 0;
  logic [5:0] address_upper;
  int n_checks = 0;
  int n_fail = 0;
  int mdl [4];

  typedef struct {
    logic       rst;
    logic       wrn;
    logic       sln;
    logic [2:0] addr;
    logic [5:0] din;
    logic       chk;
    logic [5:0] exp;
    string      name;
  } vec_t;
  vec_t vq [$];

  scc_rom_mapper_sync dut (
    .clk          (clk),
    .reset        (reset),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .sltsl_n      (sltsl_n),
    .a7_a0        (a7_a0),
    .a15_a13_a12  (a15_a13_a12),
    .data         (data),
    .address_upper(address_upper)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic w, input logic s, input int a,
                              input int d, input logic c, input int e, input string n);
    vec_t v;
    v.rst = r; v.wrn = w; v.sln = s; v.addr = 3'(a); v.din = 6'(d);
    v.chk = c; v.exp = 6'(e); v.name = n;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic w, input logic s, input logic [2:0] a,
                       input logic [5:0] d);
    @(negedge clk);
    reset = r; wr_n = w; sltsl_n = s; a15_a13_a12 = a; data = d;
    rd_n = logic'($urandom_range(0, 1));
    a7_a0 = 8'($urandom);
    #2;
  endtask

  task automatic check(input string n, input logic [5:0] exp);
    n_checks++;
    if (address_upper !== exp) begin
      n_fail++;
      $display("FAIL %s: address_upper=%0d expected=%0d (addr=%0d)", n, address_upper, exp, a15_a13_a12);
    end
  endtask

  initial begin
    add(1, 1, 0, 0, 0, 0, 0, "reset");
    for (int a = 0; a < 8; a++) add(0, 1, 0, a, 0, 1, a / 2, "reset_sweep");
    for (int p = 0; p < 4; p++) add(0, 0, 0, 2 * p + 1, 9 + 2 * p, 1, p, "write_old");
    for (int a = 0; a < 8; a++) add(0, 1, 0, a, 0, 1, 9 + 2 * (a / 2), "write_read");
    for (int p = 0; p < 4; p++) add(0, 0, 0, 2 * p, 8 + 2 * p, 1, 9 + 2 * p, "a12_low_write");
    for (int a = 0; a < 8; a++) add(0, 1, 0, a, 0, 1, 9 + 2 * (a / 2), "a12_low_read");
    add(0, 0, 1, 5, 63, 1, 13, "desel_write");
    add(0, 1, 0, 4, 0, 1, 13, "desel_read");
    add(0, 0, 0, 5, 63, 1, 13, "full_write");
    add(0, 1, 0, 4, 0, 1, 63, "full_read");
    add(0, 0, 1, 7, 5, 1, 15, "wrn_high_prep");
    add(0, 1, 0, 7, 5, 1, 15, "wrn_high_read");
    add(1, 1, 0, 0, 0, 1, 9, "reset2_pre");
    for (int a = 0; a < 8; a++) add(0, 1, 0, a, 0, 1, a / 2, "reset2_sweep");
    add(1, 0, 0, 3, 20, 1, 1, "collide_pre");
    add(0, 1, 0, 3, 0, 1, 1, "collide_read");
    add(0, 1, 0, 2, 0, 1, 1, "collide_read_lo");

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].wrn, vq[i].sln, vq[i].addr, vq[i].din);
      if (vq[i].chk) check(vq[i].name, vq[i].exp);
    end

    // Held strobe: value lands after the first edge and stays stable while held.
    drive(0, 0, 0, 3'd7, 6'd33);
    check("held_w0", 6'd3);
    drive(0, 0, 0, 3'd7, 6'd33);
    check("held_w1", 6'd33);
    drive(0, 0, 0, 3'd7, 6'd33);
    check("held_w2", 6'd33);
    drive(0, 1, 0, 3'd6, 6'd0);
    check("held_read", 6'd33);

    for (int p = 0; p < 4; p++) mdl[p] = p;
    mdl[3] = 33;
    for (int k = 0; k < 400; k++) begin
      logic r, w, s;
      logic [2:0] a;
      logic [5:0] d;
      r = ($urandom_range(0, 31) == 0);
      w = logic'($urandom_range(0, 1));
      s = logic'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = 6'($urandom);
      drive(r, w, s, a, d);
      check("random", 6'(mdl[a / 2]));
      if (r) begin
        for (int p = 0; p < 4; p++) mdl[p] = p;
      end else if (!w && !s && (a % 2 == 1)) begin
        mdl[a / 2] = d;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
